note_led_visualizer: RTL

//   Parametrised note-to-LED display driver for the synth front panel.

---
 rtl/note_led_visualizer_if.sv | 23 ++
 rtl/note_led_visualizer.sv | 70 +++++++
 2 files changed

// File: rtl/note_led_visualizer_if.sv
// Note-event bus between the key-scan logic and the LED display driver.
interface note_led_visualizer_if #(
  parameter int NUM_LEDS = 16,
  parameter int NOTE_W   = 5
);
  logic                note_valid;
  logic [NOTE_W-1:0]   note;
  logic                bar_mode;
  logic                clear;
  logic [NUM_LEDS-1:0] leds;
  logic                any_active;
  logic                note_err;

  modport master (
    output note_valid, note, bar_mode, clear,
    input  leds, any_active, note_err
  );

  modport slave (
    input  note_valid, note, bar_mode, clear,
    output leds, any_active, note_err
  );
endinterface

// File: rtl/note_led_visualizer.sv
// Note-to-LED display driver: each hit lights a slot (or a bar of slots up to it)
// and holds it for HOLD_TICKS prescaled decay ticks. Slot 0 drives the LED MSB.
module note_led_visualizer #(
  parameter int NUM_LEDS   = 16,
  parameter int NOTE_W     = 5,
  parameter int HOLD_TICKS = 8,
  parameter int TICK_DIV   = 500000,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  note_led_visualizer_if.slave bus
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PS_W-1:0]                ps_q, ps_d;
  logic [NUM_LEDS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                           err_q, err_d;
  logic                           tick;
  logic                           hit;
  logic                           in_range;
  logic [31:0]                    note_ext;
  logic [NUM_LEDS-1:0]            leds_w;

  always_comb begin
    note_ext = 32'(bus.note);
    in_range = (note_ext < 32'(NUM_LEDS));
    tick     = (ps_q == PS_W'(TICK_DIV - 1));
    ps_d     = tick ? '0 : ps_q + 1'b1;
    // Out-of-range flag is reported even when clear drops the event.
    err_d    = bus.note_valid & ~in_range;
    hit      = 1'b0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      hit = bus.note_valid & in_range &
            (bus.bar_mode ? (32'(k) <= note_ext) : (32'(k) == note_ext));
      cnt_d[k] = cnt_q[k];
      if (bus.clear)
        cnt_d[k] = '0;
      else if (hit)
        cnt_d[k] = CNT_W'(HOLD_TICKS);
      else if (tick && (cnt_q[k] != '0))
        cnt_d[k] = cnt_q[k] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ps_q  <= ps_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // LEDs decode straight from the counters so reset darkens them immediately.
  always_comb begin
    leds_w = '0;
    for (int k = 0; k < NUM_LEDS; k++)
      leds_w[NUM_LEDS-1-k] = (cnt_q[k] != '0);
  end

  assign bus.leds       = leds_w;
  assign bus.any_active = |leds_w;
  assign bus.note_err   = err_q;

endmodule
